// File: rtl/bin_to_bcd_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg : shared types and constants for the bin_to_bcd converter.
//   state_t      - converter FSM states (IDLE, SHIFT, FIN)
//   BCD_DIGIT_W  - bits per packed BCD digit
//   SEG_*        - seven-segment codes, active-high, bit order gfedcba
//   seg7_encode  - BCD digit to segment pattern (non-decimal codes go blank)
// -----------------------------------------------------------------------------
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W = 4;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg7_encode(input logic [BCD_DIGIT_W-1:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bin_to_bcd_if.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_if : request/result bundle between the adder (master) and the
// BCD converter (slave).
//   start      - level request from the adder's finish
//   in_val     - sign-magnitude value, bit MAG_W is the sign
//   busy       - converter is shifting
//   finish     - result valid, held until start drops
//   sign, bcd  - registered result (digit 0 in bcd[3:0])
//   seg, seg_minus - seven-segment view, present only with BIN_TO_BCD_SEG7_EN
// Optional feature macro: BIN_TO_BCD_SEG7_EN
// -----------------------------------------------------------------------------
interface bin_to_bcd_if #(
    parameter int MAG_W  = 15,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [MAG_W:0]        in_val;
    logic                  busy;
    logic                  finish;
    logic                  sign;
    logic [4*DIGITS-1:0]   bcd;
`ifdef BIN_TO_BCD_SEG7_EN
    logic [7*DIGITS-1:0]   seg;
    logic                  seg_minus;

    modport master (output start, in_val,
                    input  busy, finish, sign, bcd, seg, seg_minus);
    modport slave  (input  start, in_val,
                    output busy, finish, sign, bcd, seg, seg_minus);
`else
    modport master (output start, in_val,
                    input  busy, finish, sign, bcd);
    modport slave  (input  start, in_val,
                    output busy, finish, sign, bcd);
`endif
endinterface

// File: rtl/bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj : double-dabble digit correction. Adds 3 to a BCD digit of 5
// or more so that the following left shift carries into the next digit.
//   d - scratch digit in
//   q - corrected digit out
// -----------------------------------------------------------------------------
module bcd_digit_adj
    import calc_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d,
    output logic [BCD_DIGIT_W-1:0] q
);

    // add-3 correction for digits that would overflow past 9 after doubling
    always_comb begin
        q = d;
        if (d >= 4'd5) begin
            q = d + 4'd3;
        end else begin
            q = d;
        end
    end

endmodule

// File: rtl/bin_to_bcd.sv
// -----------------------------------------------------------------------------
// bin_to_bcd : converts a sign-magnitude value to packed BCD using shift-add-3,
// one magnitude bit per clock. Result valid MAG_W clocks after start is seen.
//   clk  - clock
//   RST  - synchronous active-high reset
//   bus  - bin_to_bcd_if slave port (start/in_val in; busy/finish/sign/bcd out)
// Optional feature macro: BIN_TO_BCD_SEG7_EN adds seven-segment outputs
// (seg, seg_minus) with leading-zero blanking, registered alongside bcd.
// -----------------------------------------------------------------------------
module bin_to_bcd
    import calc_pkg::*;
#(
    parameter int MAG_W  = 15,
    parameter int DIGITS = 5
) (
    input  logic        clk,
    input  logic        RST,
    bin_to_bcd_if.slave bus
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(MAG_W + 1);

    state_t             state_r;
    state_t             next_state_s;
    logic [CNT_W-1:0]   count_r;
    logic [MAG_W-1:0]   mag_r;
    logic [BCD_W-1:0]   scratch_r;
    logic [BCD_W-1:0]   adj_s;
    logic [BCD_W-1:0]   scratch_next_s;
    logic               last_iter_s;
    logic               cap_sign_r;
    logic               busy_r;
    logic               finish_r;
    logic               sign_r;
    logic [BCD_W-1:0]   bcd_r;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (scratch_r[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .q (adj_s[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // corrected scratch shifted left by one, taking in the magnitude MSB
    assign scratch_next_s = {adj_s[BCD_W-2:0], mag_r[MAG_W-1]};
    assign last_iter_s    = (count_r == CNT_W'(MAG_W - 1));

    // FSM next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    next_state_s = SHIFT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_iter_s) begin
                    next_state_s = FIN;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            FIN: begin
                if (bus.start) begin
                    next_state_s = FIN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // datapath: capture, shift-add-3 iterations, result load and status flags
    always_ff @(posedge clk) begin
        if (RST) begin
            count_r    <= '0;
            mag_r      <= '0;
            scratch_r  <= '0;
            cap_sign_r <= 1'b0;
            sign_r     <= 1'b0;
            bcd_r      <= '0;
            busy_r     <= 1'b0;
            finish_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        mag_r      <= bus.in_val[MAG_W-1:0];
                        // a zero magnitude never shows as negative
                        cap_sign_r <= bus.in_val[MAG_W] & (|bus.in_val[MAG_W-1:0]);
                        scratch_r  <= '0;
                        count_r    <= '0;
                    end
                end
                SHIFT: begin
                    scratch_r <= scratch_next_s;
                    mag_r     <= {mag_r[MAG_W-2:0], 1'b0};
                    count_r   <= count_r + CNT_W'(1);
                    if (last_iter_s) begin
                        bcd_r  <= scratch_next_s;
                        sign_r <= cap_sign_r;
                    end
                end
                FIN: begin
                    count_r <= count_r;
                end
                default: begin
                    count_r <= '0;
                end
            endcase
            busy_r   <= (next_state_s == SHIFT);
            finish_r <= (next_state_s == FIN);
        end
    end

    assign bus.busy   = busy_r;
    assign bus.finish = finish_r;
    assign bus.sign   = sign_r;
    assign bus.bcd    = bcd_r;

`ifdef BIN_TO_BCD_SEG7_EN
    logic [7*DIGITS-1:0] seg_next_s;
    logic                lead_s;
    logic [7*DIGITS-1:0] seg_r;
    logic                seg_minus_r;

    // segment patterns for the result about to load; leading zeros blank,
    // scanning from the most significant digit down, digit 0 always shown
    always_comb begin
        seg_next_s = '0;
        lead_s     = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (lead_s && (scratch_next_s[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0) && (i != 0)) begin
                seg_next_s[i*7 +: 7] = SEG_BLANK;
            end else begin
                seg_next_s[i*7 +: 7] = seg7_encode(scratch_next_s[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
                lead_s               = 1'b0;
            end
        end
    end

    // segment outputs load on the same edge as bcd
    always_ff @(posedge clk) begin
        if (RST) begin
            seg_r       <= '0;
            seg_minus_r <= 1'b0;
        end else if ((state_r == SHIFT) && last_iter_s) begin
            seg_r       <= seg_next_s;
            seg_minus_r <= cap_sign_r;
        end else begin
            seg_r       <= seg_r;
            seg_minus_r <= seg_minus_r;
        end
    end

    assign bus.seg       = seg_r;
    assign bus.seg_minus = seg_minus_r;
`endif

endmodule

// File: tb/tb_bin_to_bcd.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd : self-checking bench for bin_to_bcd (15-bit magnitude,
// 5 digits). Directed vector table plus hand sequences for hold, early start
// drop, mid-conversion reset and (with BIN_TO_BCD_SEG7_EN) segment output.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd;

    logic clk = 1'b0;
    logic rst;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    bin_to_bcd_if #(.MAG_W(15), .DIGITS(5)) bus ();

    bin_to_bcd #(.MAG_W(15), .DIGITS(5)) dut (
        .clk (clk),
        .RST (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] in_val;
        logic [19:0] exp_bcd;
        logic        exp_sign;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Raise start, measure latency and busy cycles, optionally hold start
    // after finish, then drop start and confirm finish clears next edge.
    task automatic convert(input logic [15:0] v, input logic [19:0] exp_bcd,
                           input logic exp_sign, input int hold);
        int lat;
        int busy_cnt;
        @(negedge clk);
        bus.in_val = v;
        bus.start  = 1'b1;
        @(posedge clk);
        lat      = 0;
        busy_cnt = 0;
        #1;
        while (!bus.finish && lat < 40) begin
            if (bus.busy) busy_cnt++;
            @(posedge clk);
            lat++;
            #1;
        end
        check("latency", 64'(lat), 64'd15);
        check("busy_cycles", 64'(busy_cnt), 64'd15);
        check("bcd", 64'(bus.bcd), 64'(exp_bcd));
        check("sign", 64'(bus.sign), 64'(exp_sign));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            bus.in_val = 16'h0001;
            @(posedge clk);
            #1;
            check("hold_finish", 64'(bus.finish), 64'd1);
            check("hold_busy", 64'(bus.busy), 64'd0);
            check("hold_bcd", 64'(bus.bcd), 64'(exp_bcd));
        end
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("finish_drop", 64'(bus.finish), 64'd0);
        check("idle_bcd", 64'(bus.bcd), 64'(exp_bcd));
        check("idle_sign", 64'(bus.sign), 64'(exp_sign));
    endtask

    initial begin
        int lat;
        vecs[0] = '{16'h7FFF, 20'h32767, 1'b0};
        vecs[1] = '{16'h80C8, 20'h00200, 1'b1};
        vecs[2] = '{16'h8000, 20'h00000, 1'b0};
        vecs[3] = '{16'h0001, 20'h00001, 1'b0};
        vecs[4] = '{16'h0000, 20'h00000, 1'b0};
        vecs[5] = '{16'h8001, 20'h00001, 1'b1};
        vecs[6] = '{16'h1234, 20'h04660, 1'b0};
        vecs[7] = '{16'h270F, 20'h09999, 1'b0};
        vecs[8] = '{16'h2710, 20'h10000, 1'b0};
        vecs[9] = '{16'hFFFF, 20'h32767, 1'b1};

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.in_val = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_finish", 64'(bus.finish), 64'd0);
        check("rst_sign", 64'(bus.sign), 64'd0);
        check("rst_bcd", 64'(bus.bcd), 64'd0);
`ifdef BIN_TO_BCD_SEG7_EN
        check("rst_seg", 64'(bus.seg), 64'd0);
        check("rst_seg_minus", 64'(bus.seg_minus), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            convert(vecs[i].in_val, vecs[i].exp_bcd, vecs[i].exp_sign, 0);
        end

        // start held high after finish: no reconversion, in_val changes ignored
        convert(16'h80C8, 20'h00200, 1'b1, 4);

        // start dropped and in_val changed mid-conversion: finish pulses once
        @(negedge clk);
        bus.in_val = 16'h0042;
        bus.start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start  = 1'b0;
        bus.in_val = 16'h7FFF;
        lat = 1;
        @(posedge clk);
        #1;
        while (!bus.finish && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check("drop_latency", 64'(lat), 64'd15);
        check("drop_bcd", 64'(bus.bcd), 64'h00066);
        @(posedge clk);
        #1;
        check("drop_finish_pulse", 64'(bus.finish), 64'd0);

        // reset during the 7th shift cycle
        @(negedge clk);
        bus.in_val = 16'h7FFF;
        bus.start  = 1'b1;
        @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        check("mid_busy", 64'(bus.busy), 64'd1);
        @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_busy", 64'(bus.busy), 64'd0);
        check("mrst_finish", 64'(bus.finish), 64'd0);
        check("mrst_sign", 64'(bus.sign), 64'd0);
        check("mrst_bcd", 64'(bus.bcd), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        convert(16'h0009, 20'h00009, 1'b0, 0);

`ifdef BIN_TO_BCD_SEG7_EN
        convert(16'h802A, 20'h00042, 1'b1, 0);
        check("seg_42", 64'(bus.seg), 64'({7'h00, 7'h00, 7'h00, 7'h66, 7'h5B}));
        check("seg_minus", 64'(bus.seg_minus), 64'd1);
        convert(16'h0000, 20'h00000, 1'b0, 0);
        check("seg_zero", 64'(bus.seg), 64'({7'h00, 7'h00, 7'h00, 7'h00, 7'h3F}));
        check("seg_minus_zero", 64'(bus.seg_minus), 64'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
